// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a synchronous FIFO and sends them as asynchronous serial frames
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift_reg, shift_reg_n;
  logic              tx_n, fifo_rd_n, busy_n, tx_done_n;
  logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_bit, parity_bit_n;
`endif

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_reg_n;
      tx         <= tx_n;
      fifo_rd    <= fifo_rd_n;
      busy       <= busy_n;
      tx_done    <= tx_done_n;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= parity_bit_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_cnt_n    = bit_cnt;
    shift_reg_n  = shift_reg;
    tx_n         = tx;
    fifo_rd_n    = 1'b0;
    busy_n       = busy;
    tx_done_n    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_bit_n = parity_bit;
`endif
    case (state)
      S_IDLE: begin
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        if (!fifo_empty) begin
          fifo_rd_n = 1'b1;
          busy_n    = 1'b1;
          state_n   = S_FETCH;
        end
      end
      S_FETCH: begin
        baud_cnt_n = '0;
        tx_n       = 1'b0;
        state_n    = S_START;
      end
      S_START: begin
        baud_cnt_n = baud_cnt + 1'b1;
        // The registered FIFO output lands one cycle after the read strobe is sampled.
        if (baud_cnt == '0) begin
          shift_reg_n  = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit_n = ^fifo_dout;
`endif
        end
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = shift_reg[0];
          state_n    = S_DATA;
        end
      end
      S_DATA: begin
        baud_cnt_n = baud_cnt + 1'b1;
        if (bit_end) begin
          baud_cnt_n  = '0;
          shift_reg_n = shift_reg >> 1;
          bit_cnt_n   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_n      = parity_bit;
            state_n   = S_PARITY;
`else
            tx_n      = 1'b1;
            state_n   = S_STOP;
`endif
          end else begin
            tx_n = shift_reg[1];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        baud_cnt_n = baud_cnt + 1'b1;
        if (bit_end) begin
          baud_cnt_n = '0;
          tx_n       = 1'b1;
          state_n    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        baud_cnt_n = baud_cnt + 1'b1;
        // Registered pulse: raise it one cycle early so it coincides with the last stop cycle.
        if (baud_cnt == CNT_DONE) tx_done_n = 1'b1;
        if (bit_end) begin
          baud_cnt_n = '0;
          busy_n     = 1'b0;
          tx_n       = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - randomized self-checking bench for fifo_uart_tx against a frame-level model
// Honours FIFO_UART_TX_PARITY_EN for frame length and literal bit patterns.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int L_LIT = 44;
  localparam logic [NB-1:0] LIT_A5 = 11'b10101001010;
  localparam logic [NB-1:0] LIT_01 = 11'b11000000010;
  localparam logic [NB-1:0] LIT_00 = 11'b10000000000;
  localparam logic [NB-1:0] LIT_FF = 11'b10111111110;
  localparam logic [NB-1:0] LIT_3C = 11'b10001111000;
`else
  localparam int NB = 10;
  localparam int L_LIT = 40;
  localparam logic [NB-1:0] LIT_A5 = 10'b1101001010;
  localparam logic [NB-1:0] LIT_01 = 10'b1000000010;
  localparam logic [NB-1:0] LIT_00 = 10'b1000000000;
  localparam logic [NB-1:0] LIT_FF = 10'b1111111110;
  localparam logic [NB-1:0] LIT_3C = 10'b1001111000;
`endif
  localparam int L = NB * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h5A;
  logic       fifo_rd, tx, busy, tx_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  logic       m_in = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       started = 1'b0;

  int cyc = 0, rd_pulses = 0, done_pulses = 0;
  int start_cyc = 0, done_cyc = 0, last_gap = 0, last_len = 0;
  logic prev_rd = 1'b0;
  logic [NB-1:0] cap = '0;
  logic [NB-1:0] last_cap = '0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clock(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wire bit idx of a frame: start, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Registered-output FIFO: a read sampled at an edge updates dout just after that edge.
  initial begin : fifo_model
    logic rd_seen;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen === 1'b1 && fq.size() > 0) fifo_dout = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  end

  always @(negedge clk) begin : compare
    logic e_tx, e_busy, e_rd, e_done;
    cyc++;
    if (started) begin
      if (!m_in) begin
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
      end else if (m_t == 0) begin
        e_tx = 1'b1; e_busy = 1'b1; e_rd = 1'b1; e_done = 1'b0;
      end else begin
        e_tx = frame_bit(m_byte, (m_t - 1) / C);
        e_busy = 1'b1; e_rd = 1'b0; e_done = (m_t == L);
      end
      check("tx", {31'd0, tx}, {31'd0, e_tx});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("fifo_rd", {31'd0, fifo_rd}, {31'd0, e_rd});
      check("tx_done", {31'd0, tx_done}, {31'd0, e_done});
      if (m_in && m_t >= 1 && ((m_t - 1) % C) == C / 2) cap[(m_t - 1) / C] = tx;
      if (m_in && m_t == L) last_cap = cap;
    end
    if (fifo_rd === 1'b1) rd_pulses++;
    if (prev_rd === 1'b1) begin
      start_cyc = cyc;
      last_gap  = cyc - done_cyc;
    end
    if (tx_done === 1'b1) begin
      done_pulses++;
      done_cyc = cyc;
      last_len = cyc - start_cyc + 1;
    end
    prev_rd = fifo_rd;
    // Advance the model to the cycle following the coming edge.
    if (rst) begin
      m_in = 1'b0;
      started = 1'b1;
    end else if (!m_in) begin
      if (!fifo_empty) begin
        m_in = 1'b1;
        m_t = 0;
        if (exp_q.size() > 0) m_byte = exp_q.pop_front();
        else begin
          n_tests++; n_fail++;
          $display("FAIL model_queue: got empty queue, required a byte");
        end
      end
    end else begin
      m_t++;
      if (m_t > L) m_in = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_done(input int target);
    int budget;
    int k;
    budget = (target - done_pulses + 1) * (L + 10) + 50;
    k = 0;
    while (done_pulses < target && k < budget) begin
      tick();
      k++;
    end
    if (done_pulses < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: got %0d pulses, required %0d", done_pulses, target);
    end
  endtask

  initial begin : stim
    int k;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    check("idle_rd_count", rd_pulses, 0);

    push(8'hA5);
    wait_done(1);
    check("a5_bits", {{(32-NB){1'b0}}, last_cap}, {{(32-NB){1'b0}}, LIT_A5});
    check("a5_len", last_len, L_LIT);
    tick(10);
    check("a5_rd_count", rd_pulses, 1);
    check("a5_done_count", done_pulses, 1);

    push(8'h01);
    wait_done(2);
    check("01_bits", {{(32-NB){1'b0}}, last_cap}, {{(32-NB){1'b0}}, LIT_01});

    push(8'h00);
    push(8'hFF);
    wait_done(3);
    check("00_bits", {{(32-NB){1'b0}}, last_cap}, {{(32-NB){1'b0}}, LIT_00});
    wait_done(4);
    check("ff_bits", {{(32-NB){1'b0}}, last_cap}, {{(32-NB){1'b0}}, LIT_FF});
    check("b2b_gap", last_gap, 3);
    check("b2b_rd_count", rd_pulses, 4);

    tick(100);
    check("empty_rd_count", rd_pulses, 4);
    check("empty_done_count", done_pulses, 4);

    push(8'h3C);
    k = 0;
    while (!(m_in && m_t == 4 * C + 2) && k < 200) begin
      tick();
      k++;
    end
    check("reach_data_bit3", {31'd0, (m_in && m_t == 4 * C + 2)}, 32'd1);
    rst = 1'b1;
    push(8'h3C);
    tick();
    rst = 1'b0;
    tick(2);
    check("abort_done_count", done_pulses, 4);
    wait_done(5);
    check("3c_bits", {{(32-NB){1'b0}}, last_cap}, {{(32-NB){1'b0}}, LIT_3C});
    check("3c_len", last_len, L_LIT);
    check("3c_rd_count", rd_pulses, 6);

    for (int i = 0; i < 24; i++) begin
      push(8'($urandom));
      tick($urandom_range(0, 70));
    end
    for (int t = 6; t <= 29; t++) wait_done(t);
    tick(10);
    check("rand_rd_count", rd_pulses, 30);
    check("rand_done_count", done_pulses, 29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
